arith_wback: RTL and testbench
==============================

Name: arith_wback

Overview:
- Register-file writeback stage for the GPU/DSP core.
- Sits downstream of the arithmetic unit and the load path, and drives the single register-file write port.
- Buffers ALU results behind higher-priority load data in a small FIFO.
- Keeps a 64-entry pending-load scoreboard that the issue logic checks for operand hazards.

Parameters:
- JERRY, 0, 1 = DSP build; 0 = GPU build. No behavioural difference in this block; carried for build symmetry.
- DEPTH, 2, number of ALU-result FIFO entries. Legal values are 2 or 4.

Ports:
- sys_clk  in  1  single system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- res_valid  in  1  ALU result presented this cycle.
- result  in  32  ALU result data.
- res_dst  in  6  ALU destination: {bank, reg[4:0]}.
- res_ready  out  1  FIFO can accept a result (not full).
- ld_valid  in  1  load data returning; cannot be stalled.
- ld_data  in  32  load data.
- ld_dst  in  6  load destination.
- sb_set  in  1  issue logic marks a load destination as pending.
- sb_set_addr  in  6  register to mark.
- chk_a  in  6  operand A register to check.
- chk_b  in  6  operand B register to check.
- hazard_a  out  1  operand A is not yet safe to read.
- hazard_b  out  1  operand B is not yet safe to read.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  6  register-file write address.
- rf_wdata  out  32  register-file write data.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty, so res_ready=1.
  - Scoreboard all clear, so hazard_a=hazard_b=0.
  - In-flight data is discarded.
- Write port outputs are registered. A write accepted in cycle N shows rf_we=1 in cycle N+1.
- Arbitration per cycle:
  - ld_valid=1: the load wins and the write is {ld_dst, ld_data}. The FIFO does not pop, and an incoming result is pushed.
  - ld_valid=0 and FIFO non-empty: pop the head.
  - ld_valid=0 and FIFO empty with res_valid=1: bypass. The result goes straight to the write port with 1-cycle latency and is not pushed.
  - Otherwise rf_we=0 next cycle.
- FIFO:
  - In-order, with a pointer/count design.
  - res_ready = (count < DEPTH).
  - Push and pop in the same cycle leave the count unchanged, which is legal even when full.
  - res_valid while res_ready=0 is a protocol violation. The result is dropped and state is unchanged.
- Squash: if ld_valid and ld_dst matches a valid FIFO entry, that entry is invalidated because the load is newer.
  - An invalidated entry still occupies its slot.
  - When it pops it produces rf_we=0 for that cycle.
  - More than one matching entry means all are invalidated.
- Scoreboard: 64-bit bitmap.
  - sb_set sets bit sb_set_addr.
  - A load write (ld_valid) clears bit ld_dst.
  - Set and clear of the same bit in the same cycle: set wins, because the new load is newer.
- Hazard outputs are combinational:
  - hazard_a = scoreboard[chk_a] OR (chk_a matches any valid FIFO entry) OR (rf_we AND rf_waddr==chk_a).
  - hazard_b is the same using chk_b.
- Widths: register addresses are 6 bits. Bank bit 5 is compared like any other address bit.

Optional Feature:
- Macro: ARITH_WBACK_FWD_EN.
- When defined:
  - Adds outputs fwd_a_hit (1), fwd_a_data (32), fwd_b_hit (1), fwd_b_data (32).
  - A chk match against the youngest valid FIFO entry or the registered write port returns that data with hit=1.
  - These matches then do NOT raise hazard. Only scoreboard bits raise hazard.
  - Youngest-wins priority order: FIFO tail, older FIFO entries, then the write-port register.
- When undefined: no extra ports, and hazard behaves as described under Behaviour.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=6 and NUM_REGS=64.
  - The FIFO entry typedef {valid, dst[5:0], data[31:0]}.
  - The bank-bit position constant.
- One natural sub-module, wb_fifo. It holds the DEPTH-entry FIFO with squash-by-address, and exports all entries for hazard and forward compare.
- Arbitration and the scoreboard stay in arith_wback.

Test Plan:
- Bypass: idle with empty FIFO; res_valid, res_dst=0x05, result=0x12345678 -> next cycle rf_we=1, rf_waddr=0x05, rf_wdata=0x12345678; res_ready stays 1.
- Load priority and fill:
  - ld_valid held for 3 cycles while res_valid carries dst 0x01, then 0x02 -> loads written in order, FIFO count reaches 2, res_ready=0.
  - Then ld_valid drops -> 0x01 and 0x02 written on the next two cycles, and res_ready returns to 1.
- Squash: FIFO holds dst 0x07 data 0xAAAA0000; ld_valid with ld_dst=0x07, ld_data=0x5555 -> write 0x5555; the later pop of 0x07 gives rf_we=0, and the final register value is 0x5555.
- Scoreboard: sb_set 0x23; chk_a=0x23 -> hazard_a=1 until the ld_valid to 0x23 write cycle, 0 after. Same-cycle sb_set 0x23 and ld_dst 0x23 -> bit stays set.
- Reset mid-stream: FIFO full and scoreboard bit 0x10 set; assert reset_n=0 between edges -> rf_we=0, res_ready=1, hazards 0 immediately, and no stale write after release.
- FWD_EN build: FIFO holds dst 0x09 data 0xCAFE; chk_b=0x09 -> fwd_b_hit=1, fwd_b_data=0xCAFE, hazard_b=0.

Source files
------------

// File: rtl/arith_wback_pkg.sv
// Shared types and constants for the register-file writeback stage.
package arith_wback_pkg;

    localparam int REG_ADDR_W = 6;
    localparam int NUM_REGS   = 64;
    localparam int DATA_W     = 32;
    // Bank select bit inside a register address; it takes part in every compare.
    localparam int BANK_BIT   = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // One buffered ALU result. valid=0 marks an entry squashed by a newer load.
    typedef struct packed {
        logic                  valid;
        reg_addr_t             dst;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Forwarding lookup result.
    typedef struct packed {
        logic                  hit;
        logic [DATA_W-1:0]     data;
    } fwd_t;

    // Full-address equality: the bank bit is checked exactly like the index bits.
    function automatic logic addr_eq(input reg_addr_t a, input reg_addr_t b);
        return (a[BANK_BIT] == b[BANK_BIT]) && (a[BANK_BIT-1:0] == b[BANK_BIT-1:0]);
    endfunction

endpackage

// File: rtl/arith_wback_fifo.sv
// wb_fifo: in-order ALU-result buffer with squash-by-address.
// Entries are exported oldest-first (ent_o[0] is the head); slots beyond the
// current occupancy are reported with valid=0. DEPTH must be a power of two.
module wb_fifo
    import arith_wback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  reg_addr_t               push_dst_i,
    input  logic [DATA_W-1:0]       push_data_i,
    input  logic                    pop_i,
    input  logic                    squash_i,
    input  reg_addr_t               squash_dst_i,
    output logic                    empty_o,
    output logic                    full_o,
    output wb_entry_t [DEPTH-1:0]   ent_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    wb_entry_t [DEPTH-1:0]  mem_q, mem_d;
    logic                   do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));

    // Pop only when occupied; a push into a full FIFO is fine if a pop frees the slot.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Next-state: squash matching entries first, then write the new tail.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (squash_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].valid && addr_eq(mem_q[i].dst, squash_dst_i))
                    mem_d[i].valid = 1'b0;
            end
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = '{valid: 1'b1, dst: push_dst_i, data: push_data_i};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // State registers; reset discards all buffered results.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Age-ordered view of the occupied slots.
    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
        logic [PTR_W-1:0] idx;
        assign idx      = rd_ptr_q + PTR_W'(k);
        assign ent_o[k] = '{valid: mem_q[idx].valid & (CNT_W'(k) < cnt_q),
                            dst:   mem_q[idx].dst,
                            data:  mem_q[idx].data};
    end

endmodule

// File: rtl/arith_wback.sv
// arith_wback: register-file writeback stage. Arbitrates load data (highest
// priority, never stalled) against buffered ALU results, drives the single
// registered write port, and keeps the pending-load scoreboard.
// Optional feature macro: ARITH_WBACK_FWD_EN (operand forwarding ports).
module arith_wback
    import arith_wback_pkg::*;
#(
    parameter int JERRY = 0,
    parameter int DEPTH = 2
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    input  logic                res_valid,
    input  logic [DATA_W-1:0]   result,
    input  reg_addr_t           res_dst,
    output logic                res_ready,
    input  logic                ld_valid,
    input  logic [DATA_W-1:0]   ld_data,
    input  reg_addr_t           ld_dst,
    input  logic                sb_set,
    input  reg_addr_t           sb_set_addr,
    input  reg_addr_t           chk_a,
    input  reg_addr_t           chk_b,
    output logic                hazard_a,
    output logic                hazard_b,
    output logic                rf_we,
    output reg_addr_t           rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata
`ifdef ARITH_WBACK_FWD_EN
    ,
    output logic                fwd_a_hit,
    output logic [DATA_W-1:0]   fwd_a_data,
    output logic                fwd_b_hit,
    output logic [DATA_W-1:0]   fwd_b_data
`endif
);

    // DSP and GPU builds behave identically here.
    if (JERRY != 0) begin : g_dsp_build
    end else begin : g_gpu_build
    end

    logic                   rf_we_q, rf_we_d;
    reg_addr_t              rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]      rf_wdata_q, rf_wdata_d;
    logic [NUM_REGS-1:0]    sb_q, sb_d;

    logic                   fifo_empty, fifo_full;
    logic                   push, pop, bypass;
    wb_entry_t [DEPTH-1:0]  ent;
    wb_entry_t              head;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (sys_clk),
        .rst_ni       (reset_n),
        .push_i       (push),
        .push_dst_i   (res_dst),
        .push_data_i  (result),
        .pop_i        (pop),
        .squash_i     (ld_valid),
        .squash_dst_i (ld_dst),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .ent_o        (ent)
    );

    assign head      = ent[0];
    assign res_ready = ~fifo_full;

    // Write-port arbitration: load > FIFO head > direct bypass of a fresh result.
    always_comb begin
        bypass     = ~ld_valid & fifo_empty & res_valid;
        pop        = ~ld_valid & ~fifo_empty;
        // A result offered while full is dropped.
        push       = res_valid & ~fifo_full & ~bypass;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (ld_valid) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ld_dst;
            rf_wdata_d = ld_data;
        end else if (pop) begin
            // A squashed head still drains its slot but writes nothing.
            rf_we_d = head.valid;
            if (head.valid) begin
                rf_waddr_d = head.dst;
                rf_wdata_d = head.data;
            end
        end else if (bypass) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = res_dst;
            rf_wdata_d = result;
        end
    end

    // Scoreboard update: a new pending mark outranks a clear from the returning load.
    always_comb begin
        sb_d = sb_q;
        if (ld_valid) sb_d[ld_dst]      = 1'b0;
        if (sb_set)   sb_d[sb_set_addr] = 1'b1;
    end

    // Registered write port and scoreboard.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            sb_q       <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            sb_q       <= sb_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef ARITH_WBACK_FWD_EN
    // Youngest match wins: write-port register, then FIFO oldest to newest,
    // with each later match overriding the earlier one.
    function automatic fwd_t fwd_lookup(input reg_addr_t c,
                                        input wb_entry_t [DEPTH-1:0] e,
                                        input logic we, input reg_addr_t wa,
                                        input logic [DATA_W-1:0] wd);
        fwd_t f;
        f = '0;
        if (we && addr_eq(wa, c)) f = '{hit: 1'b1, data: wd};
        for (int k = 0; k < DEPTH; k++) begin
            if (e[k].valid && addr_eq(e[k].dst, c)) f = '{hit: 1'b1, data: e[k].data};
        end
        return f;
    endfunction

    fwd_t fwd_a, fwd_b;

    // Forwardable values no longer stall; only outstanding loads do.
    always_comb begin
        fwd_a    = fwd_lookup(chk_a, ent, rf_we_q, rf_waddr_q, rf_wdata_q);
        fwd_b    = fwd_lookup(chk_b, ent, rf_we_q, rf_waddr_q, rf_wdata_q);
        hazard_a = sb_q[chk_a];
        hazard_b = sb_q[chk_b];
    end

    assign fwd_a_hit  = fwd_a.hit;
    assign fwd_a_data = fwd_a.data;
    assign fwd_b_hit  = fwd_b.hit;
    assign fwd_b_data = fwd_b.data;
`else
    function automatic logic fifo_hit(input reg_addr_t c, input wb_entry_t [DEPTH-1:0] e);
        logic h;
        h = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (e[k].valid && addr_eq(e[k].dst, c)) h = 1'b1;
        end
        return h;
    endfunction

    // A register is unsafe while a load is pending or a newer value is still in flight.
    always_comb begin
        hazard_a = sb_q[chk_a] | fifo_hit(chk_a, ent) | (rf_we_q & addr_eq(rf_waddr_q, chk_a));
        hazard_b = sb_q[chk_b] | fifo_hit(chk_b, ent) | (rf_we_q & addr_eq(rf_waddr_q, chk_b));
    end
`endif

endmodule

// File: tb/tb_arith_wback.sv
// Self-checking bench for arith_wback: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_arith_wback;

    localparam int DEPTH = 2;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic        res_valid, ld_valid, sb_set;
    logic [31:0] result, ld_data;
    logic [5:0]  res_dst, ld_dst, sb_set_addr, chk_a, chk_b;
    logic        res_ready, hazard_a, hazard_b, rf_we;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef ARITH_WBACK_FWD_EN
    logic        fwd_a_hit, fwd_b_hit;
    logic [31:0] fwd_a_data, fwd_b_data;
`endif

    always #5 sys_clk = ~sys_clk;

    arith_wback #(.JERRY(0), .DEPTH(DEPTH)) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .res_valid   (res_valid),
        .result      (result),
        .res_dst     (res_dst),
        .res_ready   (res_ready),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_dst      (ld_dst),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .chk_a       (chk_a),
        .chk_b       (chk_b),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
`ifdef ARITH_WBACK_FWD_EN
        ,
        .fwd_a_hit   (fwd_a_hit),
        .fwd_a_data  (fwd_a_data),
        .fwd_b_hit   (fwd_b_hit),
        .fwd_b_data  (fwd_b_data)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic v; logic [5:0] d; logic [31:0] x; } ment_t;
    ment_t       q[$];          // front = oldest buffered result
    logic [63:0] sb;
    logic        wv;            // expected write-port state
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [31:0] obs_rf [64];   // register file as written by the DUT

    function automatic void m_reset();
        q.delete();
        sb = '0;
        wv = 1'b0;
    endfunction

    function automatic logic m_haz(input logic [5:0] c);
        logic h;
        h = sb[c];
`ifndef ARITH_WBACK_FWD_EN
        foreach (q[i]) if (q[i].v && q[i].d == c) h = 1'b1;
        if (wv && wa == c) h = 1'b1;
`endif
        return h;
    endfunction

`ifdef ARITH_WBACK_FWD_EN
    function automatic logic [32:0] m_fwd(input logic [5:0] c);
        logic [32:0] f;
        f = '0;
        if (wv && wa == c) f = {1'b1, wd};
        foreach (q[i]) if (q[i].v && q[i].d == c) f = {1'b1, q[i].x};
        return f;
    endfunction
`endif

    // Apply one clock edge of the writeback rules to the model.
    function automatic void m_edge();
        ment_t e;
        logic  full;
        full = (q.size() >= DEPTH);
        if (ld_valid) begin
            foreach (q[i]) if (q[i].d == ld_dst) q[i].v = 1'b0;
            wv = 1'b1; wa = ld_dst; wd = ld_data;
            if (res_valid && !full) q.push_back('{1'b1, res_dst, result});
        end else if (q.size() > 0) begin
            e  = q.pop_front();
            wv = e.v;
            if (e.v) begin wa = e.d; wd = e.x; end
            if (res_valid && !full) q.push_back('{1'b1, res_dst, result});
        end else if (res_valid) begin
            wv = 1'b1; wa = res_dst; wd = result;
        end else begin
            wv = 1'b0;
        end
        if (ld_valid) sb[ld_dst] = 1'b0;
        if (sb_set)   sb[sb_set_addr] = 1'b1;
    endfunction

    // ---------------- bench plumbing ----------------
    task automatic idle();
        res_valid = 0; result = '0; res_dst = '0;
        ld_valid = 0; ld_data = '0; ld_dst = '0;
        sb_set = 0; sb_set_addr = '0; chk_a = '0; chk_b = '0;
    endtask

    task automatic check_outs();
`ifdef ARITH_WBACK_FWD_EN
        logic [32:0] f;
`endif
        expect_eq("rf_we", rf_we, wv);
        if (wv) begin
            expect_eq("rf_waddr", rf_waddr, wa);
            expect_eq("rf_wdata", rf_wdata, wd);
        end
        if (rf_we === 1'b1) obs_rf[rf_waddr] = rf_wdata;
        expect_eq("res_ready", res_ready, q.size() < DEPTH);
        expect_eq("hazard_a", hazard_a, m_haz(chk_a));
        expect_eq("hazard_b", hazard_b, m_haz(chk_b));
`ifdef ARITH_WBACK_FWD_EN
        f = m_fwd(chk_a);
        expect_eq("fwd_a_hit", fwd_a_hit, f[32]);
        if (f[32]) expect_eq("fwd_a_data", fwd_a_data, f[31:0]);
        f = m_fwd(chk_b);
        expect_eq("fwd_b_hit", fwd_b_hit, f[32]);
        if (f[32]) expect_eq("fwd_b_data", fwd_b_data, f[31:0]);
`endif
    endtask

    // Inputs are set just after a falling edge; check, clock, advance model.
    task automatic step();
        #1 check_outs();
        @(posedge sys_clk);
        m_edge();
        @(negedge sys_clk);
    endtask

    function automatic logic [5:0] rnd_addr();
        logic [5:0] a;
        a = 6'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) a = a | 6'h20;
        return a;
    endfunction

    initial begin
        reset_n = 1'b0;
        idle();
        m_reset();
        #2;
        expect_eq("rst_we", rf_we, 0);
        expect_eq("rst_waddr", rf_waddr, 0);
        expect_eq("rst_wdata", rf_wdata, 0);
        expect_eq("rst_ready", res_ready, 1);
        expect_eq("rst_haz_a", hazard_a, 0);
        expect_eq("rst_haz_b", hazard_b, 0);
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;

        // Bypass from an empty, idle stage.
        res_valid = 1; res_dst = 6'h05; result = 32'h1234_5678;
        step();
        idle();
        #1;
        expect_eq("byp_we", rf_we, 1);
        expect_eq("byp_waddr", rf_waddr, 6'h05);
        expect_eq("byp_wdata", rf_wdata, 32'h1234_5678);
        expect_eq("byp_ready", res_ready, 1);
        step();

        // Loads win while results fill the FIFO, then the FIFO drains in order.
        ld_valid = 1; ld_dst = 6'h30; ld_data = 32'h3030;
        res_valid = 1; res_dst = 6'h01; result = 32'h0000_0011;
        step();
        ld_dst = 6'h31; ld_data = 32'h3131;
        res_dst = 6'h02; result = 32'h0000_0022;
        step();
        ld_dst = 6'h32; ld_data = 32'h3232; res_valid = 0;
        #1;
        expect_eq("fill_ready", res_ready, 0);
        expect_eq("fill_ld_waddr", rf_waddr, 6'h31);
        step();
        idle();
        step();
        #1;
        expect_eq("drain1_waddr", rf_waddr, 6'h01);
        expect_eq("drain1_wdata", rf_wdata, 32'h11);
        expect_eq("drain1_ready", res_ready, 1);
        step();
        #1;
        expect_eq("drain2_waddr", rf_waddr, 6'h02);
        expect_eq("drain2_wdata", rf_wdata, 32'h22);
        step();

        // Squash: a newer load to the same register kills the buffered result.
        ld_valid = 1; ld_dst = 6'h3F; ld_data = 32'h1;
        res_valid = 1; res_dst = 6'h07; result = 32'hAAAA_0000;
        step();
        ld_dst = 6'h07; ld_data = 32'h5555; res_valid = 0;
        step();
        idle();
        #1;
        expect_eq("sq_ld_waddr", rf_waddr, 6'h07);
        expect_eq("sq_ld_wdata", rf_wdata, 32'h5555);
        step();
        #1 expect_eq("sq_pop_we", rf_we, 0);
        step();
        step();
        expect_eq("sq_final", obs_rf[7], 32'h5555);

        // Scoreboard: pending until the load returns; a same-cycle set wins.
        sb_set = 1; sb_set_addr = 6'h23; chk_a = 6'h23;
        step();
        idle(); chk_a = 6'h23;
        #1 expect_eq("sb_pend", hazard_a, 1);
        step();
        ld_valid = 1; ld_dst = 6'h23; ld_data = 32'h2323; chk_a = 6'h23;
        #1 expect_eq("sb_ldcyc", hazard_a, 1);
        step();
        idle(); chk_a = 6'h23;
        step();
        #1 expect_eq("sb_clr", hazard_a, 0);
        step();
        sb_set = 1; sb_set_addr = 6'h23; ld_valid = 1; ld_dst = 6'h23; ld_data = 32'h77;
        step();
        idle(); chk_a = 6'h23;
        step();
        step();
        #1 expect_eq("sb_setwins", hazard_a, 1);
        step();
        ld_valid = 1; ld_dst = 6'h23;
        step();
        idle();
        step();
        step();

        // Buffered result seen by an operand check (forwarded or stalled).
        ld_valid = 1; ld_dst = 6'h3E; ld_data = 32'h3E;
        res_valid = 1; res_dst = 6'h09; result = 32'h0000_CAFE;
        step();
        ld_dst = 6'h3D; res_valid = 0; chk_b = 6'h09;
        #1;
`ifdef ARITH_WBACK_FWD_EN
        expect_eq("fwd_hit", fwd_b_hit, 1);
        expect_eq("fwd_data", fwd_b_data, 32'h0000_CAFE);
        expect_eq("fwd_haz", hazard_b, 0);
`else
        expect_eq("buf_haz", hazard_b, 1);
`endif
        step();
        idle();
        step();
        step();

        // Reset mid-stream with a full FIFO and a pending load.
        ld_valid = 1; ld_dst = 6'h3C; ld_data = 32'h3C;
        res_valid = 1; res_dst = 6'h11; result = 32'h1111;
        sb_set = 1; sb_set_addr = 6'h10;
        step();
        ld_dst = 6'h3B; res_dst = 6'h12; result = 32'h1212; sb_set = 0;
        step();
        idle(); chk_a = 6'h10; chk_b = 6'h11;
        #1;
        expect_eq("mid_full", res_ready, 0);
        expect_eq("mid_haz_a", hazard_a, 1);
        #1 reset_n = 1'b0;
        m_reset();
        #1;
        expect_eq("mid_rst_we", rf_we, 0);
        expect_eq("mid_rst_ready", res_ready, 1);
        expect_eq("mid_rst_haz_a", hazard_a, 0);
        expect_eq("mid_rst_haz_b", hazard_b, 0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        reset_n = 1'b1;
        step();
        #1 expect_eq("rst_nostale", rf_we, 0);
        step();

        // Random traffic, mostly protocol-legal, with occasional full-FIFO offers.
        for (int i = 0; i < 400; i++) begin
            ld_valid    = ($urandom_range(0, 9) < 3);
            ld_dst      = rnd_addr();
            ld_data     = $urandom;
            res_valid   = ($urandom_range(0, 9) < 6) &&
                          (q.size() < DEPTH || $urandom_range(0, 19) == 0);
            res_dst     = rnd_addr();
            result      = $urandom;
            sb_set      = ($urandom_range(0, 4) == 0);
            sb_set_addr = rnd_addr();
            chk_a       = rnd_addr();
            chk_b       = rnd_addr();
            step();
        end
        idle();
        step();
        step();
        #1 check_outs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
